// File: rtl/button_cmd_arbiter.sv
// Merges per-button press pulses (plus optional auto-repeat) into one round-robin
// command channel with a valid/ready handshake and a cooldown gap after each accept.
module button_cmd_arbiter #(
    parameter int                N_BTN         = 4,
    parameter int                COOLDOWN      = 8,
    parameter int                REPEAT_DELAY  = 20,
    parameter int                REPEAT_PERIOD = 10,
    parameter logic [N_BTN-1:0]  REPEAT_MASK   = '0,
    localparam int               IDW           = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_BTN-1:0] btn_pulse,
    input  logic [N_BTN-1:0] btn_held,
    output logic             cmd_valid,
    output logic [IDW-1:0]   cmd_id,
    input  logic             cmd_ready,
    output logic             cmd_dropped,
    output logic             busy
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int CDW  = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        COOL
    } state_t;

    state_t           state;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] rep_armed;
    logic [RW-1:0]    rep_cnt [N_BTN];
    logic [N_BTN-1:0] repeat_fire;
    logic [N_BTN-1:0] evt;
    logic [N_BTN-1:0] clear_vec;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_id;
    logic [IDW:0]     scan_idx;
    logic [CDW-1:0]   cd_cnt;
    logic             handshake;

    assign handshake = cmd_valid & cmd_ready;

    always_comb begin
        clear_vec = '0;
        for (int i = 0; i < N_BTN; i++) begin
            repeat_fire[i] = REPEAT_MASK[i] & rep_armed[i] & btn_held[i] & (rep_cnt[i] == RW'(1));
        end
        evt = (btn_pulse | repeat_fire) & {N_BTN{enable}};
        if (handshake) begin
            clear_vec[cmd_id] = 1'b1;
        end
    end

    // Scan downwards in offset so the set bit nearest rr_ptr is the last one written.
    always_comb begin
        grant_id = '0;
        scan_idx = '0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr} + (IDW + 1)'(k);
            if (scan_idx >= (IDW + 1)'(N_BTN)) begin
                scan_idx = scan_idx - (IDW + 1)'(N_BTN);
            end
            if (pending[scan_idx[IDW-1:0]]) begin
                grant_id = scan_idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BTN; i++) begin
            if (rst || !REPEAT_MASK[i]) begin
                rep_armed[i] <= 1'b0;
                rep_cnt[i]   <= '0;
            end else if (btn_pulse[i]) begin
                rep_armed[i] <= 1'b1;
                rep_cnt[i]   <= RW'(REPEAT_DELAY);
            end else if (!btn_held[i]) begin
                rep_armed[i] <= 1'b0;
                rep_cnt[i]   <= '0;
            end else if (rep_armed[i]) begin
                rep_cnt[i] <= (rep_cnt[i] == RW'(1)) ? RW'(REPEAT_PERIOD) : rep_cnt[i] - RW'(1);
            end
        end
    end

    // A new event on the button being accepted this cycle re-arms it rather than counting as a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= '0;
            rr_ptr      <= '0;
            cd_cnt      <= '0;
            cmd_valid   <= 1'b0;
            cmd_id      <= '0;
            cmd_dropped <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pending     <= (pending & ~clear_vec) | evt;
            cmd_dropped <= |(evt & pending & ~clear_vec);
            case (state)
                IDLE: begin
                    if (enable && (|pending)) begin
                        cmd_id    <= grant_id;
                        cmd_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (handshake) begin
                        cmd_valid <= 1'b0;
                        rr_ptr    <= (cmd_id == IDW'(N_BTN - 1)) ? '0 : cmd_id + IDW'(1);
                        if (COOLDOWN == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state  <= COOL;
                            cd_cnt <= CDW'(COOLDOWN);
                        end
                    end
                end
                COOL: begin
                    if (cd_cnt == CDW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cd_cnt <= cd_cnt - CDW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_cmd_arbiter.sv
// Bench for button_cmd_arbiter: directed scenarios plus a long random run checked
// against a timestamp-based reference model.
module tb_button_cmd_arbiter;

    localparam int         N    = 4;
    localparam int         CD   = 3;
    localparam int         RD   = 5;
    localparam int         RP   = 2;
    localparam logic [3:0] MASK = 4'b0011;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] btn_pulse;
    logic [3:0] btn_held;
    logic       cmd_valid;
    logic [1:0] cmd_id;
    logic       cmd_ready;
    logic       cmd_dropped;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] m_pending;
    int         m_arm [4];
    bit         m_offer;
    int         m_id;
    int         m_rr;
    int         m_idle_from;
    bit         m_drop;
    bit         m_busy;
    int         cyc = 0;

    button_cmd_arbiter #(
        .N_BTN(N), .COOLDOWN(CD), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .btn_pulse(btn_pulse), .btn_held(btn_held),
        .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_ready(cmd_ready),
        .cmd_dropped(cmd_dropped), .busy(busy)
    );

    always #5 clk = ~clk;

    // Repeats are derived from the time since arming; the channel is free again at a known edge.
    task automatic model_update();
        logic [3:0] fire;
        logic [3:0] ev;
        logic [3:0] nxt;
        bit         hs;
        int         e;
        int         j;
        if (rst) begin
            m_pending = '0;
            for (int i = 0; i < 4; i++) m_arm[i] = -1;
            m_offer = 0; m_id = 0; m_rr = 0; m_drop = 0; m_busy = 0;
            m_idle_from = cyc + 1;
        end else begin
            hs = m_offer && cmd_ready;
            fire = '0;
            for (int i = 0; i < 4; i++) begin
                if (MASK[i] && m_arm[i] >= 0 && btn_held[i]) begin
                    e = cyc - m_arm[i];
                    fire[i] = (e >= RD) && ((e - RD) % RP == 0);
                end
                ev[i] = (btn_pulse[i] | fire[i]) & enable;
                if (MASK[i]) begin
                    if (btn_pulse[i]) m_arm[i] = cyc;
                    else if (!btn_held[i]) m_arm[i] = -1;
                end
            end
            m_drop = 0;
            for (int i = 0; i < 4; i++) begin
                if (ev[i] && m_pending[i] && !(hs && m_id == i)) m_drop = 1;
            end
            nxt = m_pending;
            if (hs) nxt[m_id] = 1'b0;
            nxt = nxt | ev;
            if (m_offer) begin
                if (hs) begin
                    m_offer = 0;
                    m_rr = (m_id + 1) % N;
                    m_idle_from = cyc + CD + 1;
                end
            end else if (cyc >= m_idle_from && enable && m_pending != 0) begin
                j = -1;
                for (int k = 0; k < N; k++) begin
                    if (j < 0 && m_pending[(m_rr + k) % N]) j = (m_rr + k) % N;
                end
                m_offer = 1;
                m_id = j;
            end
            m_pending = nxt;
            m_busy = m_offer || (cyc + 1 < m_idle_from);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_pulse = '0;
        btn_held = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; cmd_ready = 1'b1; btn_pulse = 4'hF; btn_held = 4'hF;
        step();
        step();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", cmd_valid); end
        checks++; if (cmd_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_id: got %0d expected 0", cmd_id); end
        checks++; if (cmd_dropped !== 1'b0) begin errors++; $display("[TB] FAIL reset_drop: got %b expected 0", cmd_dropped); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0; btn_pulse = '0; btn_held = '0;
        step();
        step();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_capture: got %b expected 0", cmd_valid); end
    endtask

    task automatic test_single();
        int first_k = -1;
        int valid_n = 0;
        int busy_n = 0;
        int id_seen = -1;
        do_reset();
        enable = 1'b1; cmd_ready = 1'b1;
        btn_pulse = 4'b0100;
        step();
        btn_pulse = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) step();
            if (cmd_valid === 1'b1) begin
                valid_n++;
                id_seen = int'(cmd_id);
                if (first_k < 0) first_k = k;
            end
            if (busy === 1'b1) busy_n++;
        end
        checks++; if (first_k != 2) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 2", first_k); end
        checks++; if (id_seen != 2) begin errors++; $display("[TB] FAIL single_id: got %0d expected 2", id_seen); end
        checks++; if (valid_n != 1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", valid_n); end
        checks++; if (busy_n != 4) begin errors++; $display("[TB] FAIL single_busy_cycles: got %0d expected 4", busy_n); end
    endtask

    task automatic test_round_robin();
        int ids [3] = '{-1, -1, -1};
        int ks [3] = '{-1, -1, -1};
        int n = 0;
        do_reset();
        enable = 1'b1; cmd_ready = 1'b1;
        btn_pulse = 4'b1011;
        step();
        btn_pulse = '0;
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) step();
            if (cmd_valid === 1'b1) begin
                if (n < 3) begin ids[n] = int'(cmd_id); ks[n] = k; end
                n++;
            end
        end
        checks++; if (n != 3) begin errors++; $display("[TB] FAIL rr_count: got %0d expected 3", n); end
        checks++; if (ids[0] != 0) begin errors++; $display("[TB] FAIL rr_id0: got %0d expected 0", ids[0]); end
        checks++; if (ids[1] != 1) begin errors++; $display("[TB] FAIL rr_id1: got %0d expected 1", ids[1]); end
        checks++; if (ids[2] != 3) begin errors++; $display("[TB] FAIL rr_id2: got %0d expected 3", ids[2]); end
        checks++; if (ks[1] - ks[0] != CD + 2) begin errors++; $display("[TB] FAIL rr_gap01: got %0d expected %0d", ks[1] - ks[0], CD + 2); end
        checks++; if (ks[2] - ks[1] != CD + 2) begin errors++; $display("[TB] FAIL rr_gap12: got %0d expected %0d", ks[2] - ks[1], CD + 2); end
        btn_pulse = 4'b1101;
        step();
        btn_pulse = '0;
        for (int w = 0; w < 6 && cmd_valid !== 1'b1; w++) step();
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("[TB] FAIL rr_wrap_timeout: got valid %b expected 1", cmd_valid); end
        checks++; if (cmd_id !== 2'd0) begin errors++; $display("[TB] FAIL rr_wrap_id: got %0d expected 0", cmd_id); end
    endtask

    task automatic test_stall_drop();
        int bad_valid = 0;
        int bad_id = 0;
        int bad_drop = 0;
        int later = 0;
        do_reset();
        enable = 1'b1; cmd_ready = 1'b0;
        btn_pulse = 4'b0010;
        step();
        btn_pulse = '0;
        for (int w = 0; w < 6 && cmd_valid !== 1'b1; w++) step();
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_offer_timeout: got valid %b expected 1", cmd_valid); end
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) btn_pulse = 4'b0010;
            step();
            btn_pulse = '0;
            if (cmd_valid !== 1'b1) bad_valid++;
            if (cmd_id !== 2'd1) bad_id++;
            if (cmd_dropped !== (k == 3)) bad_drop++;
        end
        checks++; if (bad_valid != 0) begin errors++; $display("[TB] FAIL stall_valid_stable: got %0d bad cycles expected 0", bad_valid); end
        checks++; if (bad_id != 0) begin errors++; $display("[TB] FAIL stall_id_stable: got %0d bad cycles expected 0", bad_id); end
        checks++; if (bad_drop != 0) begin errors++; $display("[TB] FAIL stall_drop_pulse: got %0d bad cycles expected 0", bad_drop); end
        cmd_ready = 1'b1;
        step();
        for (int k = 1; k <= 12; k++) begin
            step();
            if (cmd_valid === 1'b1) later++;
        end
        checks++; if (later != 0) begin errors++; $display("[TB] FAIL stall_merged: got %0d extra offers expected 0", later); end
    endtask

    task automatic test_repeat();
        logic [31:0] vmask = '0;
        logic [31:0] dmask = '0;
        logic [31:0] exp_v = '0;
        logic [31:0] exp_d = '0;
        int bad_id = 0;
        exp_v[2] = 1'b1; exp_v[7] = 1'b1; exp_v[12] = 1'b1; exp_v[17] = 1'b1;
        exp_d[10] = 1'b1; exp_d[12] = 1'b1;
        do_reset();
        enable = 1'b1; cmd_ready = 1'b1;
        btn_held = 4'b0001;
        btn_pulse = 4'b0001;
        step();
        btn_pulse = '0;
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) step();
            vmask[k] = (cmd_valid === 1'b1);
            dmask[k] = (cmd_dropped === 1'b1);
            if (cmd_valid === 1'b1 && cmd_id !== 2'd0) bad_id++;
            if (k >= 14) btn_held = '0;
        end
        checks++; if (vmask !== exp_v) begin errors++; $display("[TB] FAIL repeat_offers: got %h expected %h", vmask, exp_v); end
        checks++; if (dmask !== exp_d) begin errors++; $display("[TB] FAIL repeat_drops: got %h expected %h", dmask, exp_d); end
        checks++; if (bad_id != 0) begin errors++; $display("[TB] FAIL repeat_id: got %0d wrong ids expected 0", bad_id); end
    endtask

    task automatic test_set_wins();
        int n2 = 0;
        int n1 = 0;
        int drops = 0;
        do_reset();
        enable = 1'b1; cmd_ready = 1'b1;
        btn_held = 4'b0100;
        btn_pulse = 4'b0100;
        step();
        btn_pulse = '0;
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) step();
            if (cmd_valid === 1'b1) n2++;
            if (k >= 19) btn_held = '0;
        end
        checks++; if (n2 != 1) begin errors++; $display("[TB] FAIL nomask_single_cmd: got %0d expected 1", n2); end
        btn_pulse = 4'b0010;
        step();
        btn_pulse = '0;
        for (int w = 0; w < 6 && cmd_valid !== 1'b1; w++) step();
        checks++; if (cmd_valid !== 1'b1 || cmd_id !== 2'd1) begin errors++; $display("[TB] FAIL setwin_first: got valid %b id %0d expected 1 id 1", cmd_valid, cmd_id); end
        btn_pulse = 4'b0010;
        step();
        btn_pulse = '0;
        for (int k = 1; k <= 15; k++) begin
            if (k > 1) step();
            if (cmd_valid === 1'b1 && cmd_id === 2'd1) n1++;
            if (cmd_dropped === 1'b1) drops++;
        end
        checks++; if (n1 != 1) begin errors++; $display("[TB] FAIL setwin_second: got %0d offers expected 1", n1); end
        checks++; if (drops != 0) begin errors++; $display("[TB] FAIL setwin_no_drop: got %0d drops expected 0", drops); end
    endtask

    task automatic test_reset_mid();
        int later = 0;
        do_reset();
        enable = 1'b1; cmd_ready = 1'b0;
        btn_pulse = 4'b1000;
        step();
        btn_pulse = '0;
        for (int w = 0; w < 6 && cmd_valid !== 1'b1; w++) step();
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_offer_timeout: got valid %b expected 1", cmd_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_offer_valid: got %b expected 0", cmd_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_offer_busy: got %b expected 0", busy); end
        cmd_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (cmd_valid === 1'b1) later++;
        end
        checks++; if (later != 0) begin errors++; $display("[TB] FAIL midrst_offer_pending: got %0d offers expected 0", later); end
        btn_pulse = 4'b0001;
        step();
        btn_pulse = '0;
        for (int w = 0; w < 6 && cmd_valid !== 1'b1; w++) step();
        step();
        checks++; if (busy !== 1'b1 || cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_cool_state: got busy %b valid %b expected 1 0", busy, cmd_valid); end
        btn_pulse = 4'b0010;
        step();
        btn_pulse = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_cool_clear: got busy %b valid %b expected 0 0", busy, cmd_valid); end
        later = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (cmd_valid === 1'b1) later++;
        end
        checks++; if (later != 0) begin errors++; $display("[TB] FAIL midrst_cool_pending: got %0d offers expected 0", later); end
    endtask

    task automatic test_enable_off();
        int offers = 0;
        int drops = 0;
        do_reset();
        enable = 1'b0; cmd_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            btn_pulse = 4'($urandom);
            btn_held = 4'($urandom);
            step();
            if (cmd_valid === 1'b1) offers++;
            if (cmd_dropped === 1'b1) drops++;
        end
        btn_pulse = '0; btn_held = '0;
        for (int k = 0; k < 30; k++) begin
            if (k == 15) enable = 1'b1;
            step();
            if (cmd_valid === 1'b1) offers++;
            if (cmd_dropped === 1'b1) drops++;
        end
        checks++; if (offers != 0) begin errors++; $display("[TB] FAIL enable_off_offers: got %0d expected 0", offers); end
        checks++; if (drops != 0) begin errors++; $display("[TB] FAIL enable_off_drops: got %0d expected 0", drops); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 499) == 0);
            enable = ($urandom_range(0, 15) != 0);
            cmd_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 4; i++) begin
                btn_pulse[i] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 11) == 0) btn_held[i] = ~btn_held[i];
            end
            step();
            checks++; if (cmd_valid !== m_offer) begin errors++; $display("[TB] FAIL rand_valid cyc %0d: got %b expected %b", cyc, cmd_valid, m_offer); end
            if (m_offer) begin
                checks++; if (cmd_id !== 2'(m_id)) begin errors++; $display("[TB] FAIL rand_id cyc %0d: got %0d expected %0d", cyc, cmd_id, m_id); end
            end
            checks++; if (cmd_dropped !== m_drop) begin errors++; $display("[TB] FAIL rand_drop cyc %0d: got %b expected %b", cyc, cmd_dropped, m_drop); end
            checks++; if (busy !== m_busy) begin errors++; $display("[TB] FAIL rand_busy cyc %0d: got %b expected %b", cyc, busy, m_busy); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; cmd_ready = 1'b0; btn_pulse = '0; btn_held = '0;
        m_pending = '0; m_offer = 0; m_id = 0; m_rr = 0; m_idle_from = 0; m_drop = 0; m_busy = 0;
        for (int i = 0; i < 4; i++) m_arm[i] = -1;
        test_reset();
        test_single();
        test_round_robin();
        test_stall_drop();
        test_repeat();
        test_set_wins();
        test_reset_mid();
        test_enable_off();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
